// File: rtl/cpu_pkg.sv
// Shared definitions for the boot-time program loader.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN enables the trailing XOR checksum stage.
package cpu_pkg;

    localparam int unsigned HEADER_BYTES   = 4;
    localparam int unsigned BYTES_PER_WORD = 4;

    typedef enum logic [2:0] {
        StHeader,
        StPayload,
        StCheck,
        StDone,
        StError
    } loader_state_t;

    // Header length is checked in 33 bits so that 0xFFFFFFFF cannot wrap into range.
    function automatic logic is_oversize(input logic [31:0] n, input int unsigned aw);
        logic [32:0] w_cap;
        w_cap = 33'd1 << aw;
        return {1'b0, n} > w_cap;
    endfunction

endpackage

// File: rtl/loader_hdr_parse.sv
// Length-header parser: collects four big-endian bytes into the 32-bit word count N.
// N and hdr_done are presented in the same cycle the fourth byte arrives, so the
// framing FSM can act on the header without an extra cycle of latency.
module loader_hdr_parse
    import cpu_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_en,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic [31:0] o_n,
    output logic        o_hdr_done
);

    // Only the first three bytes need storage; the fourth is merged combinationally.
    logic [23:0] r_shift;
    logic [1:0]  r_cnt;
    logic        w_take;

    assign w_take     = i_en && i_valid;
    assign o_n        = {r_shift, i_data};
    assign o_hdr_done = w_take && (r_cnt == 2'(HEADER_BYTES - 1));

    // Shift header bytes in MSB-first and count them.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_take) begin
            r_shift <= {r_shift[15:0], i_data};
            r_cnt   <= r_cnt + 2'd1;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader: parses a 4-byte length header from the UART byte
// stream and forwards 4*N payload bytes to inst_fetch with start/end framing.
// Optional build macro PROGRAM_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte
// that must match before the load is reported done.
module program_loader
    import cpu_pkg::*;
#(
    parameter int unsigned INST_MEM_WIDTH = 2
) (
    input  logic                      CLK,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_valid,
    output logic [7:0]                input_data,
    output logic                      input_valid,
    output logic                      input_start,
    output logic                      input_end,
    output logic [INST_MEM_WIDTH:0]   word_count,
    output logic                      done,
    output logic                      error
);

    loader_state_t           r_state;
    logic [7:0]              r_data;
    logic                    r_valid;
    logic                    r_start;
    logic                    r_end;
    logic                    r_done;
    logic                    r_error;
    logic [INST_MEM_WIDTH:0] r_word_count;
    logic [INST_MEM_WIDTH:0] r_n_words;
    logic [1:0]              r_byte_cnt;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    logic [7:0]              r_xor;
`endif

    logic                    w_hdr_en;
    logic [31:0]             w_n;
    logic                    w_hdr_done;
    logic                    w_oversize;
    logic                    w_n_zero;
    logic [INST_MEM_WIDTH:0] w_words_next;
    logic                    w_word_end;
    logic                    w_last;

    assign w_hdr_en = (r_state == StHeader);

    loader_hdr_parse u_hdr_parse (
        .i_clk      (CLK),
        .i_reset    (reset),
        .i_en       (w_hdr_en),
        .i_valid    (rx_valid),
        .i_data     (rx_data),
        .o_n        (w_n),
        .o_hdr_done (w_hdr_done)
    );

    assign w_oversize   = is_oversize(w_n, INST_MEM_WIDTH);
    assign w_n_zero     = (w_n == 32'd0);
    assign w_words_next = r_word_count + 1'b1;
    assign w_word_end   = (r_byte_cnt == 2'(BYTES_PER_WORD - 1));
    // N never exceeds capacity once in payload, so it fits in the word counter width.
    assign w_last       = w_word_end && (w_words_next == r_n_words);

    assign input_data  = r_data;
    assign input_valid = r_valid;
    assign input_start = r_start;
    assign input_end   = r_end;
    assign word_count  = r_word_count;
    assign done        = r_done;
    assign error       = r_error;

    // Framing FSM with registered outputs; strobes default low every cycle.
    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state      <= StHeader;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_start      <= 1'b0;
            r_end        <= 1'b0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_word_count <= '0;
            r_n_words    <= '0;
            r_byte_cnt   <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
            r_xor        <= '0;
`endif
        end else begin
            r_valid <= 1'b0;
            r_end   <= 1'b0;
            unique case (r_state)
                StHeader: begin
                    if (w_hdr_done) begin
                        if (w_oversize) begin
                            r_error <= 1'b1;
                            r_state <= StError;
                        end else if (w_n_zero) begin
                            // Empty program: open and close the frame in one cycle.
                            r_start <= 1'b1;
                            r_end   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_start   <= 1'b1;
                            r_n_words <= w_n[INST_MEM_WIDTH:0];
                            r_state   <= StPayload;
                        end
                    end
                end
                StPayload: begin
                    if (rx_valid) begin
                        r_valid    <= 1'b1;
                        r_data     <= rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                        r_xor      <= r_xor ^ rx_data;
`endif
                        if (w_word_end) begin
                            r_word_count <= w_words_next;
                        end
                        if (w_last) begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                            r_state <= StCheck;
`else
                            r_end   <= 1'b1;
                            r_done  <= 1'b1;
                            r_state <= StDone;
`endif
                        end
                    end
                end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
                StCheck: begin
                    // Checksum byte closes the frame whether or not it matches.
                    if (rx_valid) begin
                        r_end <= 1'b1;
                        if (rx_data == r_xor) begin
                            r_done  <= 1'b1;
                            r_state <= StDone;
                        end else begin
                            r_error <= 1'b1;
                            r_state <= StError;
                        end
                    end
                end
`endif
                StDone, StError: begin
                    r_start <= 1'b0;
                end
                default: begin
                    r_start <= 1'b0;
                    r_error <= 1'b1;
                    r_state <= StError;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed scenarios plus randomized
// streams, compared cycle by cycle against a byte-count based reference model.
module tb_program_loader;

    localparam int unsigned W   = 2;
    localparam int unsigned CAP = 1 << W;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    logic         CLK = 1'b0;
    logic         reset;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic [7:0]   input_data;
    logic         input_valid;
    logic         input_start;
    logic         input_end;
    logic [W:0]   word_count;
    logic         done;
    logic         error;

    always #5 CLK = ~CLK;

    program_loader #(
        .INST_MEM_WIDTH (W)
    ) dut (
        .CLK         (CLK),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .input_data  (input_data),
        .input_valid (input_valid),
        .input_start (input_start),
        .input_end   (input_end),
        .word_count  (word_count),
        .done        (done),
        .error       (error)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: header bytes seen, payload bytes seen, final outcome.
    int          m_hdr;
    int          m_pay;
    int          m_fin;   // 0 loading, 1 done, 2 error
    logic [31:0] m_n;
    logic [7:0]  m_x;
    logic        e_valid, e_start, e_end;
    logic [7:0]  e_data;
    int          e_wc;

    task automatic model_step(input logic rs, input logic v, input logic [7:0] d);
        e_valid = 1'b0;
        e_end   = 1'b0;
        if (rs) begin
            m_hdr   = 0;
            m_pay   = 0;
            m_fin   = 0;
            m_n     = '0;
            m_x     = '0;
            e_data  = '0;
            e_start = 1'b0;
            e_wc    = 0;
        end else if (m_fin != 0) begin
            e_start = 1'b0;
        end else if (m_hdr < 4) begin
            if (v) begin
                m_n = {m_n[23:0], d};
                m_hdr++;
                if (m_hdr == 4) begin
                    if (m_n > 32'(CAP)) begin
                        m_fin = 2;
                    end else if (m_n == 0) begin
                        e_start = 1'b1;
                        e_end   = 1'b1;
                        m_fin   = 1;
                    end else begin
                        e_start = 1'b1;
                    end
                end
            end
        end else if (m_pay < 4 * int'(m_n)) begin
            if (v) begin
                e_valid = 1'b1;
                e_data  = d;
                m_pay++;
                m_x     = m_x ^ d;
                e_wc    = m_pay / 4;
                if (m_pay == 4 * int'(m_n) && !CK) begin
                    e_end = 1'b1;
                    m_fin = 1;
                end
            end
        end else begin
            if (v) begin
                e_end = 1'b1;
                m_fin = (d == m_x) ? 1 : 2;
            end
        end
    endtask

    task automatic step(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge CLK);
        model_step(reset, v, d);
        #1;
        check_eq("input_valid", 32'(input_valid), 32'(e_valid));
        check_eq("input_data", 32'(input_data), 32'(e_data));
        check_eq("input_start", 32'(input_start), 32'(e_start));
        check_eq("input_end", 32'(input_end), 32'(e_end));
        check_eq("word_count", 32'(word_count), 32'(e_wc));
        check_eq("done", 32'(done), (m_fin == 1) ? 32'd1 : 32'd0);
        check_eq("error", 32'(error), (m_fin == 2) ? 32'd1 : 32'd0);
        if (input_valid) check_eq("valid_needs_start", 32'(input_start), 32'd1);
    endtask

    task automatic idle(input int k);
        repeat (k) step(1'b0, 8'($urandom));
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        idle(gap);
        step(1'b1, b);
    endtask

    task automatic send_hdr(input logic [31:0] n, input int gap);
        for (int i = 3; i >= 0; i--) send(n[8*i +: 8], gap);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 8'h00);
        reset = 1'b0;
    endtask

    logic [7:0] prog [8] = '{8'h00, 8'hc2, 8'h10, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        step(1'b0, 8'h00);
        step(1'b0, 8'h00);
        reset = 1'b0;
        check_eq("reset_start", 32'(input_start), 32'd0);
        idle(2);

        // Two words on spaced strobes; trailing byte after done is ignored.
        send_hdr(32'd2, 1);
        for (int i = 0; i < 8; i++) send(prog[i], 2);
        check_eq("s1_end_with_last", 32'(input_end), 32'd1);
        check_eq("s1_last_data", 32'(input_data), 32'h44);
        idle(3);
        send(8'hAA, 0);
        check_eq("s1_word_count", 32'(word_count), 32'd2);
        check_eq("s1_done", 32'(done), 32'd1);
        do_reset();

        // Same stream back to back.
        send_hdr(32'd2, 0);
        for (int i = 0; i < 8; i++) send(prog[i], 0);
        idle(2);
        check_eq("s2_word_count", 32'(word_count), 32'd2);
        do_reset();

        // Oversize header.
        send_hdr(32'd5, 0);
        for (int i = 0; i < 4; i++) send(prog[i], 0);
        idle(2);
        check_eq("s3_error", 32'(error), 32'd1);
        do_reset();

        // Empty program.
        send_hdr(32'd0, 1);
        check_eq("s4_start", 32'(input_start), 32'd1);
        check_eq("s4_end", 32'(input_end), 32'd1);
        idle(3);
        check_eq("s4_done", 32'(done), 32'd1);
        do_reset();

        // Reset mid-payload, then a fresh one-word load.
        send_hdr(32'd2, 0);
        for (int i = 0; i < 3; i++) send(prog[i], 0);
        do_reset();
        check_eq("s5_after_reset_start", 32'(input_start), 32'd0);
        send_hdr(32'd1, 0);
        for (int i = 0; i < 4; i++) send(prog[i], 1);
        idle(2);
        check_eq("s5_done", 32'(done), 32'd1);
        do_reset();

`ifdef PROGRAM_LOADER_CHECKSUM_EN
        send_hdr(32'd1, 0);
        for (int i = 0; i < 4; i++) send(prog[i], 0);
        send(8'hd6, 1);
        check_eq("ck_good_end", 32'(input_end), 32'd1);
        idle(2);
        check_eq("ck_good_done", 32'(done), 32'd1);
        do_reset();
        send_hdr(32'd1, 0);
        for (int i = 0; i < 4; i++) send(prog[i], 0);
        send(8'h00, 0);
        check_eq("ck_bad_end", 32'(input_end), 32'd1);
        idle(2);
        check_eq("ck_bad_error", 32'(error), 32'd1);
        do_reset();
`endif

        // Randomized streams with random gaps, checksums and occasional mid-stream reset.
        for (int t = 0; t < 40; t++) begin
            logic [31:0] n;
            logic [7:0]  q[$];
            logic [7:0]  x;
            logic [7:0]  b;
            int          r;
            int          npay;
            int          rst_at;
            r = $urandom_range(0, 9);
            if (r <= 4)      n = 32'(r);
            else if (r == 5) n = 32'(CAP + 1);
            else if (r == 6) n = 32'hFFFF_FFFF;
            else if (r == 7) n = $urandom;
            else             n = 32'($urandom_range(1, CAP));
            q.delete();
            for (int i = 3; i >= 0; i--) q.push_back(n[8*i +: 8]);
            npay = (n <= 32'(CAP)) ? 4 * int'(n) : 3;
            x = 8'h00;
            for (int i = 0; i < npay; i++) begin
                b = 8'($urandom);
                q.push_back(b);
                x = x ^ b;
            end
            if (CK && n != 0 && n <= 32'(CAP)) q.push_back(($urandom_range(0, 1) == 1) ? x : x ^ 8'h5a);
            q.push_back(8'($urandom));
            q.push_back(8'($urandom));
            rst_at = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, q.size() - 1)) : -1;
            for (int i = 0; i < q.size(); i++) begin
                if (i == rst_at) do_reset();
                send(q[i], int'($urandom_range(0, 2)));
            end
            idle(2);
            do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
